// File: rtl/single_port_ram.sv
// -----------------------------------------------------------------------------
// single_port_ram
//
// Synchronous single-port RAM, DEPTH words x DATA_WIDTH bits. One address is
// shared by reads and writes. Read data is registered (one-cycle latency) and
// read-during-write is write-first: the word being written appears on q.
// A synchronous reset clears q and the entire array on a single edge, and it
// takes priority over any write presented on that edge.
//
// Ports:
//   clk   in   1           rising-edge clock
//   rst   in   1           synchronous, active-high reset (wins over we)
//   data  in   DATA_WIDTH  write data
//   addr  in   ADDR_WIDTH  word address for both read and write
//   we    in   1           write enable, active high
//   q     out  DATA_WIDTH  registered read data
//
// DEPTH must equal 2**ADDR_WIDTH, so every address value maps to a real word
// and there is no out-of-range case to handle.
// -----------------------------------------------------------------------------
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    // Storage and read register. The declaration initialisers give the
    // all-zero power-up state so q never shows X before the first reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] q_q           = '0;
    logic [DATA_WIDTH-1:0] q_d;

    // Next read value: write-first, so a write forwards its own data instead
    // of the word stored before the edge.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves q_d
        // unassigned; a missing default in always_comb infers a latch.
        q_d = mem_q[addr];
        if (we) begin
            q_d = data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            q_q   <= '0;
            // NOTE: clearing every word in one edge is a functional
            // requirement here; it rules out mapping onto a plain RAM macro,
            // which cannot be bulk-cleared.
            mem_q <= '{default: '0};
        end else begin
            q_q <= q_d;
            if (we) begin
                mem_q[addr] <= data;
            end
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_single_port_ram.sv
// -----------------------------------------------------------------------------
// tb_single_port_ram
//
// Scoreboard bench for single_port_ram. The driver applies one operation per
// cycle on the falling edge and pushes the value q must hold after the next
// rising edge, computed from a plain array model of the memory. A separate
// monitor samples q shortly after each rising edge and compares it against
// the front of the queue.
// -----------------------------------------------------------------------------
module tb_single_port_ram;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] q;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q [$];
    string         tag_q [$];

    // Reference model: the memory contents as the rules describe them.
    logic [DW-1:0] ref_mem [DEPTH];

    single_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .data(data),
        .addr(addr),
        .we  (we),
        .q   (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: q=%h expected=%h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Issue one operation for the coming rising edge and record what q must
    // show after that edge.
    task automatic op(input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input string tag);
        logic [DW-1:0] expv;
        @(negedge clk);
        rst  = r;
        we   = w;
        addr = a;
        data = d;
        if (r) begin
            expv = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (w) begin
            expv = d;
            ref_mem[a] = d;
        end else begin
            expv = ref_mem[a];
        end
        exp_q.push_back(expv);
        tag_q.push_back(tag);
    endtask

    // Monitor: the RAM presents a fresh q after every edge; compare whenever
    // an expectation is outstanding.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check(tag_q.pop_front(), q, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst  = 1'b0;
        we   = 1'b0;
        addr = '0;
        data = '0;

        // Power-up value before any edge.
        #1;
        check("powerup_q", q, 8'h00);

        // Reset then read.
        op(1, 0, 6'd0,  8'h00, "reset_edge");
        op(0, 0, 6'd0,  8'h00, "rd_after_rst_0");
        op(0, 0, 6'd2,  8'h00, "rd_after_rst_2");
        op(0, 0, 6'd63, 8'h00, "rd_after_rst_63");

        // Back-to-back writes, then readback in a different order.
        op(0, 1, 6'd0, 8'h01, "wr_0");
        op(0, 1, 6'd1, 8'h02, "wr_1");
        op(0, 1, 6'd3, 8'h03, "wr_3");
        op(0, 0, 6'd0, 8'h00, "rd_0");
        op(0, 0, 6'd1, 8'h00, "rd_1");
        op(0, 0, 6'd3, 8'h00, "rd_3");
        op(0, 0, 6'd2, 8'h00, "rd_2_unwritten");

        // Write-first, then hold via a read of the same word.
        op(0, 1, 6'd5, 8'hA5, "write_first_5");
        op(0, 0, 6'd5, 8'h00, "rd_after_wr_5");

        // Overwrite, neighbours untouched.
        op(0, 1, 6'd7, 8'h11, "wr_7_a");
        op(0, 1, 6'd7, 8'h22, "wr_7_b");
        op(0, 0, 6'd7, 8'h00, "rd_7_last_wins");
        op(0, 0, 6'd6, 8'h00, "rd_6_neighbour");
        op(0, 0, 6'd8, 8'h00, "rd_8_neighbour");

        // Address extremes, no aliasing.
        op(0, 1, 6'd63, 8'hFF, "wr_63");
        op(0, 1, 6'd0,  8'h80, "wr_0_ext");
        op(0, 0, 6'd63, 8'h00, "rd_63");
        op(0, 0, 6'd0,  8'h00, "rd_0_ext");

        // Reset priority over a coinciding write.
        op(0, 1, 6'd10, 8'h55, "wr_10");
        op(1, 1, 6'd10, 8'h66, "rst_with_write");
        op(0, 0, 6'd10, 8'h00, "rd_10_after_rst");
        op(0, 0, 6'd63, 8'h00, "rd_63_after_rst");

        // Randomised traffic, biased toward a few addresses so reads often
        // hit written words, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            bit            r;
            bit            w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            r = ($urandom_range(0, 63) == 0);
            w = $urandom_range(0, 1);
            a = $urandom_range(0, 1) ? AW'($urandom_range(0, 7))
                                     : AW'($urandom_range(0, DEPTH - 1));
            d = DW'($urandom);
            op(r, w, a, d, "random");
        end

        // Drain the scoreboard with a bounded wait.
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
